// File: rtl/apple_bus_pkg.sv
// Shared types and constants for the Apple II slot bus host: bus states,
// cycle lengths and the slot-select decode bases.
package apple_bus_pkg;

  typedef enum logic [2:0] {
    S1 = 3'd0,
    S2 = 3'd1,
    S3 = 3'd2,
    S4 = 3'd3,
    S5 = 3'd4,
    S6 = 3'd5,
    S7 = 3'd6,
    S8 = 3'd7
  } state_t;

  localparam int CYCLE_LEN        = 7;
  localparam int LONG_CYCLE_LEN   = 8;
  localparam int CYCLES_PER_FRAME = 65;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] DEVSEL_BASE = 16'hC080;
  localparam logic [ADDR_W-1:0] IOSEL_BASE  = 16'hC000;
  localparam logic [ADDR_W-1:0] IOSTRB_BASE = 16'hC800;

endpackage

// File: rtl/apple_bus_timing.sv
// Bus cycle sequencer: walks S1..S7 each bus cycle, stretching every 65th
// cycle with S8, and flags the final state of each cycle.
module apple_bus_timing
  import apple_bus_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  output state_t state,
  output logic   phi1,
  output logic   phi0,
  output logic   last
);

  localparam logic [6:0] LONG_IDX   = 7'(CYCLES_PER_FRAME - 1);
  localparam state_t     LAST_SHORT = state_t'(CYCLE_LEN - 1);
  localparam state_t     LAST_LONG  = state_t'(LONG_CYCLE_LEN - 1);

  state_t     state_nxt;
  logic [6:0] cycle;
  logic [6:0] cycle_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S1;
      cycle <= 7'd0;
    end else begin
      state <= state_nxt;
      cycle <= cycle_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cycle_nxt = cycle;
    case (state)
      LAST_SHORT: begin
        if (cycle == LONG_IDX) begin
          state_nxt = LAST_LONG;
        end else begin
          state_nxt = S1;
          cycle_nxt = cycle + 7'd1;
        end
      end
      LAST_LONG: begin
        state_nxt = S1;
        cycle_nxt = 7'd0;
      end
      default: state_nxt = state_t'(state + 3'd1);
    endcase
  end

  assign phi1 = state inside {S1, S2, S3};
  assign phi0 = ~phi1;
  // The long cycle ends in S8, so S7 is only final when not in cycle 64.
  assign last = (state == LAST_LONG) || ((state == LAST_SHORT) && (cycle != LONG_IDX));

endmodule

// File: rtl/apple_bus_host.sv
// Apple II slot bus host: turns one command per bus cycle into address,
// R/W, data and slot selects, and returns read data with a response pulse.
module apple_bus_host
  import apple_bus_pkg::*;
#(
  parameter int SLOT         = 7,
  parameter int RESET_CYCLES = 16
) (
  input  logic        C7M,
  input  logic        RES,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        PHI1,
  output logic        PHI0,
  output logic [15:0] A,
  output logic        nWE,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        nDEVSEL,
  output logic        nIOSEL,
  output logic        nIOSTRB,
  output logic        nRESout
);

  state_t      state;
  logic        last;
  logic        accept;
  logic        pending;
  logic [15:0] rst_cnt;
  logic        sel_phase;
  logic        dev_hit;
  logic        io_hit;
  logic        strb_hit;

  apple_bus_timing u_timing (
    .clk   (C7M),
    .rst   (RES),
    .state (state),
    .phi1  (PHI1),
    .phi0  (PHI0),
    .last  (last)
  );

  assign cmd_ready = last & nRESout;
  assign accept    = cmd_valid & cmd_ready;

  // Everything bus-visible changes only on the edge leaving the final state.
  always_ff @(posedge C7M) begin
    if (RES) begin
      A         <= 16'hFFFF;
      nWE       <= 1'b1;
      D_out     <= 8'h00;
      pending   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      nRESout   <= 1'b0;
      rst_cnt   <= 16'd0;
    end else begin
      rsp_valid <= 1'b0;
      if (last) begin
        rsp_valid <= pending;
        if (pending) begin
          rsp_rdata <= nWE ? D_in : 8'h00;
        end
        if (accept) begin
          A       <= cmd_addr;
          nWE     <= ~cmd_we;
          D_out   <= cmd_wdata;
          pending <= 1'b1;
        end else begin
          A       <= 16'hFFFF;
          nWE     <= 1'b1;
          D_out   <= 8'h00;
          pending <= 1'b0;
        end
        if (!nRESout) begin
          if (rst_cnt == 16'(RESET_CYCLES - 1)) begin
            nRESout <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 16'd1;
          end
        end
      end
    end
  end

  assign sel_phase = state inside {S4, S5, S6, S7, S8};
  assign dev_hit   = A[15:4]  == (DEVSEL_BASE[15:4] + 12'(SLOT));
  assign io_hit    = A[15:8]  == (IOSEL_BASE[15:8] + 8'(SLOT));
  assign strb_hit  = A[15:11] == IOSTRB_BASE[15:11];

  assign nDEVSEL = ~(sel_phase & dev_hit);
  assign nIOSEL  = ~(sel_phase & io_hit);
  assign nIOSTRB = ~(sel_phase & strb_hit);
  assign D_oe    = ~nWE & (state inside {S5, S6, S7, S8});

endmodule

// File: tb/tb_apple_bus_host.sv
// Bench for apple_bus_host: a C7M-count timing model checks every output on
// every clock, plus directed vectors and reset/period sequences.
module tb_apple_bus_host;

  localparam int SLOT  = 6;
  localparam int RC    = 16;
  localparam int FRAME = 456;

  logic        C7M = 1'b0;
  logic        RES = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_we = 1'b0;
  logic [15:0] cmd_addr = 16'h0000;
  logic [7:0]  cmd_wdata = 8'h00;
  logic [7:0]  D_in = 8'h00;
  logic        cmd_ready, rsp_valid, PHI1, PHI0, nWE, D_oe;
  logic        nDEVSEL, nIOSEL, nIOSTRB, nRESout;
  logic [7:0]  rsp_rdata, D_out;
  logic [15:0] A;

  apple_bus_host #(.SLOT(SLOT), .RESET_CYCLES(RC)) dut (
    .C7M(C7M), .RES(RES), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .PHI1(PHI1), .PHI0(PHI0),
    .A(A), .nWE(nWE), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
    .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB), .nRESout(nRESout)
  );

  always #5 C7M = ~C7M;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model: t counts C7M edges since the reset edge.
  int          t = 0;
  logic        m_cmd = 1'b0, m_we = 1'b0, m_rv = 1'b0, m_acc = 1'b0;
  logic [15:0] m_addr = 16'hFFFF;
  logic [7:0]  m_wdata = 8'h00, m_rd = 8'h00;

  function automatic int cyc_of(int tt);
    int p = tt % FRAME;
    return (p < 448) ? p / 7 : 64;
  endfunction

  function automatic int st_of(int tt);
    int p = tt % FRAME;
    return (p < 448) ? p % 7 : p - 448;
  endfunction

  function automatic int g_of(int tt);
    return (tt / FRAME) * 65 + cyc_of(tt);
  endfunction

  function automatic bit final_of(int tt);
    return (st_of(tt) == 7) || (st_of(tt) == 6 && cyc_of(tt) != 64);
  endfunction

  function automatic bit in_rng(logic [15:0] a, int lo, int hi);
    return (int'(a) >= lo) && (int'(a) <= hi);
  endfunction

  function automatic void model_edge();
    m_acc = 1'b0;
    if (RES) begin
      t = 0; m_cmd = 0; m_we = 0; m_addr = 16'hFFFF; m_wdata = 0; m_rv = 0; m_rd = 0;
    end else begin
      if (final_of(t)) begin
        m_rv = m_cmd;
        if (m_cmd) m_rd = m_we ? 8'h00 : D_in;
        if (cmd_valid && g_of(t) >= RC) begin
          m_acc = 1'b1; m_cmd = 1'b1; m_we = cmd_we; m_addr = cmd_addr; m_wdata = cmd_wdata;
        end else begin
          m_cmd = 1'b0; m_we = 1'b0; m_addr = 16'hFFFF; m_wdata = 8'h00;
        end
      end else begin
        m_rv = 1'b0;
      end
      t++;
    end
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
    end
  endfunction

  function automatic void check_all();
    int st = st_of(t);
    logic [15:0] ea = m_cmd ? m_addr : 16'hFFFF;
    logic e_nres = (g_of(t) >= RC);
    logic [41:0] exp_v, act_v;
    exp_v = {st < 3, st >= 3, ea, ~(m_cmd & m_we), m_wdata, m_cmd & m_we & (st >= 4),
             ~((st >= 3) & in_rng(ea, 'hC080 + SLOT * 16, 'hC080 + SLOT * 16 + 15)),
             ~((st >= 3) & in_rng(ea, 'hC000 + SLOT * 256, 'hC000 + SLOT * 256 + 255)),
             ~((st >= 3) & in_rng(ea, 'hC800, 'hCFFF)),
             e_nres, final_of(t) & e_nres, m_rv, m_rd};
    act_v = {PHI1, PHI0, A, nWE, D_out, D_oe, nDEVSEL, nIOSEL, nIOSTRB,
             nRESout, cmd_ready, rsp_valid, rsp_rdata};
    check("bus_outputs", 64'(act_v), 64'(exp_v));
  endfunction

  task automatic tick();
    @(posedge C7M);
    model_edge();
    @(negedge C7M);
    check_all();
  endtask

  typedef struct {
    logic        long_c;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic [7:0]  rd;
    int          dev, io, strb, oe;
  } vec_t;

  vec_t vecs[11];

  task automatic wait_nres_clks(input string name);
    int n = 0;
    while (!nRESout && n < 300) begin tick(); n++; end
    check(name, 64'(n), 64'(RC * 7));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, rises, n8, nodd, sum, last_rise, hold_acc, hold_rdy;
    bit prev;
    int c_dev, c_io, c_strb, c_oe;
    logic [15:0] bases [6];

    vecs[0]  = '{1'b0, 1'b0, 16'hC0E3, 8'h00, 8'h5A, 8'h5A, 4, 0, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 16'hC600, 8'hA5, 8'h3C, 8'h00, 0, 4, 0, 3};
    vecs[2]  = '{1'b1, 1'b0, 16'hCFFF, 8'h00, 8'hC3, 8'hC3, 0, 0, 5, 0};
    vecs[3]  = '{1'b0, 1'b1, 16'hCE00, 8'h11, 8'h77, 8'h00, 0, 0, 4, 3};
    vecs[4]  = '{1'b0, 1'b0, 16'hC6FF, 8'h00, 8'hE7, 8'hE7, 0, 4, 0, 0};
    vecs[5]  = '{1'b0, 1'b0, 16'hC0EF, 8'h00, 8'h01, 8'h01, 4, 0, 0, 0};
    vecs[6]  = '{1'b0, 1'b0, 16'hC0F0, 8'h00, 8'h02, 8'h02, 0, 0, 0, 0};
    vecs[7]  = '{1'b0, 1'b0, 16'hC0DF, 8'h00, 8'h03, 8'h03, 0, 0, 0, 0};
    vecs[8]  = '{1'b1, 1'b1, 16'hC0E0, 8'h99, 8'h44, 8'h00, 5, 0, 0, 4};
    vecs[9]  = '{1'b0, 1'b0, 16'hC7FF, 8'h00, 8'h80, 8'h80, 0, 0, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 16'hC800, 8'h00, 8'h6E, 8'h6E, 0, 0, 4, 0};
    bases = '{16'hC0E0, 16'hC600, 16'hC800, 16'hC080, 16'hC700, 16'h0000};

    // Reset state
    RES = 1'b1;
    tick(); tick();
    check("rst_nresout", 64'(nRESout), 64'd0);
    check("rst_addr", 64'(A), 64'hFFFF);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_phi1", 64'(PHI1), 64'd1);
    RES = 1'b0;
    wait_nres_clks("nres_rise_clks");

    // PHI1 period over one full frame
    rises = 0; n8 = 0; nodd = 0; sum = 0; last_rise = 0; prev = PHI1; n = 0;
    while (rises < 66 && n < 1000) begin
      tick(); n++;
      if (PHI1 && !prev) begin
        if (rises > 0) begin
          sum += n - last_rise;
          if (n - last_rise == 8) n8++;
          else if (n - last_rise != 7) nodd++;
        end
        last_rise = n; rises++;
      end
      prev = PHI1;
    end
    check("phi1_rises", 64'(rises), 64'd66);
    check("frame_clks", 64'(sum), 64'd456);
    check("long_cycles", 64'(n8), 64'd1);
    check("odd_periods", 64'(nodd), 64'd0);

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      n = 0;
      if (vecs[i].long_c) while (cyc_of(t) != 63 && n < 600) begin tick(); n++; end
      cmd_valid = 1'b1; cmd_we = vecs[i].we; cmd_addr = vecs[i].addr;
      cmd_wdata = vecs[i].wdata; D_in = vecs[i].din;
      k = 0;
      do begin tick(); k++; end while (!m_acc && k < 600);
      check($sformatf("v%0d_accept", i), 64'(m_acc), 64'd1);
      cmd_valid = 1'b0; cmd_addr = 16'h1234; cmd_wdata = 8'hEE;
      c_dev = 0; c_io = 0; c_strb = 0; c_oe = 0; k = 0;
      do begin
        c_dev += int'(!nDEVSEL); c_io += int'(!nIOSEL);
        c_strb += int'(!nIOSTRB); c_oe += int'(D_oe);
        tick(); k++;
      end while (!m_rv && k < 20);
      check($sformatf("v%0d_len", i), 64'(k), vecs[i].long_c ? 64'd8 : 64'd7);
      check($sformatf("v%0d_rvalid", i), 64'(rsp_valid), 64'd1);
      check($sformatf("v%0d_rdata", i), 64'(rsp_rdata), 64'(vecs[i].rd));
      check($sformatf("v%0d_devsel", i), 64'(c_dev), 64'(vecs[i].dev));
      check($sformatf("v%0d_iosel", i), 64'(c_io), 64'(vecs[i].io));
      check($sformatf("v%0d_iostrb", i), 64'(c_strb), 64'(vecs[i].strb));
      check($sformatf("v%0d_oe", i), 64'(c_oe), 64'(vecs[i].oe));
    end

    // cmd_valid held high: one acceptance per cycle
    hold_acc = 0; hold_rdy = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 140; i++) begin
      cmd_addr = 16'(bases[$urandom_range(0, 5)] + 16'($urandom_range(0, 255)));
      cmd_we = 1'($urandom); cmd_wdata = 8'($urandom); D_in = 8'($urandom);
      hold_rdy += int'(cmd_ready);
      tick();
      hold_acc += int'(m_acc);
    end
    cmd_valid = 1'b0;
    check("hold_accepts", 64'(hold_acc), 64'(hold_rdy));

    // Randomized traffic, including rare resets
    for (int i = 0; i < 4000; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_we    = 1'($urandom);
      cmd_addr  = 16'(bases[$urandom_range(0, 5)] + 16'($urandom_range(0, 255)));
      cmd_wdata = 8'($urandom);
      D_in      = 8'($urandom);
      RES       = ($urandom_range(0, 999) == 0);
      tick();
    end
    RES = 1'b0; cmd_valid = 1'b0;
    n = 0;
    while (g_of(t) < RC + 1 && n < 300) begin tick(); n++; end

    // Reset during S5 of a write
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'hC600; cmd_wdata = 8'h5C;
    k = 0;
    do begin tick(); k++; end while (!m_acc && k < 600);
    cmd_valid = 1'b0;
    k = 0;
    while (st_of(t) != 4 && k < 10) begin tick(); k++; end
    check("s5_doe", 64'(D_oe), 64'd1);
    RES = 1'b1;
    tick();
    RES = 1'b0;
    check("abort_doe", 64'(D_oe), 64'd0);
    check("abort_iosel", 64'(nIOSEL), 64'd1);
    check("abort_nres", 64'(nRESout), 64'd0);
    check("abort_rvalid", 64'(rsp_valid), 64'd0);
    wait_nres_clks("nres_restart_clks");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
